// File: rtl/alu_74ls181.sv
// rtl/alu_74ls181.sv - registered 4-bit 74LS181-style ALU slice (16 logic + 16 arithmetic functions)
// Optional ALU_PG_EN adds registered group propagate/generate outputs P and G.
module alu_74ls181 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] sel,
    input  logic       mode,
    input  logic       cin,
    output logic [3:0] F,
    output logic       cout,
    output logic       eqAB
`ifdef ALU_PG_EN
    ,
    output logic       P,
    output logic       G
`endif
);

    logic [3:0] x_op;
    logic [3:0] y_op;
    logic [3:0] logic_f;
    logic [4:0] sum;
    logic [4:0] sum_nc;
    logic [3:0] next_f;
    logic       next_cout;

    // Arithmetic functions are all "X plus Y plus cin" with operands picked by sel.
    always_comb begin
        x_op = A;
        y_op = 4'b0000;
        unique case (sel)
            4'b0000: begin x_op = A;        y_op = 4'b0000;  end
            4'b0001: begin x_op = A | B;    y_op = 4'b0000;  end
            4'b0010: begin x_op = A | ~B;   y_op = 4'b0000;  end
            4'b0011: begin x_op = 4'b0000;  y_op = 4'b1111;  end
            4'b0100: begin x_op = A;        y_op = A & ~B;   end
            4'b0101: begin x_op = A | B;    y_op = A & ~B;   end
            4'b0110: begin x_op = A;        y_op = ~B;       end
            4'b0111: begin x_op = A & ~B;   y_op = 4'b1111;  end
            4'b1000: begin x_op = A;        y_op = A & B;    end
            4'b1001: begin x_op = A;        y_op = B;        end
            4'b1010: begin x_op = A | ~B;   y_op = A & B;    end
            4'b1011: begin x_op = A & B;    y_op = 4'b1111;  end
            4'b1100: begin x_op = A;        y_op = A;        end
            4'b1101: begin x_op = A | B;    y_op = A;        end
            4'b1110: begin x_op = A | ~B;   y_op = A;        end
            default: begin x_op = A;        y_op = 4'b1111;  end
        endcase
    end

    always_comb begin
        logic_f = 4'b0000;
        unique case (sel)
            4'b0000: logic_f = ~A;
            4'b0001: logic_f = ~(A | B);
            4'b0010: logic_f = ~A & B;
            4'b0011: logic_f = 4'b0000;
            4'b0100: logic_f = ~(A & B);
            4'b0101: logic_f = ~B;
            4'b0110: logic_f = A ^ B;
            4'b0111: logic_f = A & ~B;
            4'b1000: logic_f = ~A | B;
            4'b1001: logic_f = ~(A ^ B);
            4'b1010: logic_f = B;
            4'b1011: logic_f = A & B;
            4'b1100: logic_f = 4'b1111;
            4'b1101: logic_f = A | ~B;
            4'b1110: logic_f = A | B;
            default: logic_f = A;
        endcase
    end

    assign sum       = {1'b0, x_op} + {1'b0, y_op} + {4'b0000, cin};
    assign sum_nc    = {1'b0, x_op} + {1'b0, y_op};
    assign next_f    = mode ? logic_f : sum[3:0];
    assign next_cout = mode ? 1'b0 : sum[4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F    <= 4'b0000;
            cout <= 1'b0;
            eqAB <= 1'b0;
        end else begin
            F    <= next_f;
            cout <= next_cout;
            eqAB <= (next_f == 4'b1111);
        end
    end

`ifdef ALU_PG_EN
    // Group terms exclude cin so that cout == G | (P & cin) for lookahead chaining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            P <= 1'b0;
            G <= 1'b0;
        end else begin
            P <= mode ? 1'b0 : &(x_op ^ y_op);
            G <= mode ? 1'b0 : sum_nc[4];
        end
    end
`endif

endmodule

// File: tb/tb_alu_74ls181.sv
// tb/tb_alu_74ls181.sv - scoreboard testbench for alu_74ls181 (ALU_PG_EN adds P/G checks)
module tb_alu_74ls181;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A = 4'd0;
    logic [3:0] B = 4'd0;
    logic [3:0] sel = 4'd0;
    logic       mode = 1'b0;
    logic       cin = 1'b0;
    logic [3:0] F;
    logic       cout;
    logic       eqAB;
`ifdef ALU_PG_EN
    logic       P;
    logic       G;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] f;
        logic       co;
        logic       eq;
        logic       p;
        logic       g;
        logic       m;
        logic       c;
    } exp_t;

    exp_t sb[$];

    alu_74ls181 dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .sel(sel), .mode(mode), .cin(cin),
        .F(F), .cout(cout), .eqAB(eqAB)
`ifdef ALU_PG_EN
        , .P(P), .G(G)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference in the datasheet's own words: "A minus 1" is A plus 15, etc.
    function automatic logic [4:0] arith_ref(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] s, input logic c);
        int ai = int'(a);
        int bi = int'(b);
        int nb = 15 - bi;
        int r;
        case (s)
            4'd0:  r = ai;
            4'd1:  r = ai | bi;
            4'd2:  r = ai | nb;
            4'd3:  r = 15;
            4'd4:  r = ai + (ai & nb);
            4'd5:  r = (ai | bi) + (ai & nb);
            4'd6:  r = ai - bi - 1 + 16;
            4'd7:  r = (ai & nb) + 15;
            4'd8:  r = ai + (ai & bi);
            4'd9:  r = ai + bi;
            4'd10: r = (ai | nb) + (ai & bi);
            4'd11: r = (ai & bi) + 15;
            4'd12: r = ai + ai;
            4'd13: r = (ai | bi) + ai;
            4'd14: r = (ai | nb) + ai;
            default: r = ai + 15;
        endcase
        r = r + int'(c);
        return r[4:0];
    endfunction

    function automatic logic [3:0] logic_ref(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] s);
        case (s)
            4'd0:  return ~a;
            4'd1:  return ~(a | b);
            4'd2:  return ~a & b;
            4'd3:  return 4'b0000;
            4'd4:  return ~(a & b);
            4'd5:  return ~b;
            4'd6:  return a ^ b;
            4'd7:  return a & ~b;
            4'd8:  return ~a | b;
            4'd9:  return ~(a ^ b);
            4'd10: return b;
            4'd11: return a & b;
            4'd12: return 4'b1111;
            4'd13: return a | ~b;
            4'd14: return a | b;
            default: return a;
        endcase
    endfunction

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] s, input logic m, input logic c);
        exp_t e;
        logic [4:0] r1;
        logic [4:0] r0;
        r1 = arith_ref(a, b, s, c);
        r0 = arith_ref(a, b, s, 1'b0);
        e.m = m;
        e.c = c;
        if (m) begin
            e.f = logic_ref(a, b, s);
            e.co = 1'b0;
            e.p = 1'b0;
            e.g = 1'b0;
        end else begin
            e.f = r1[3:0];
            e.co = r1[4];
            e.g = r0[4];
            e.p = (r0 == 5'd15);
        end
        e.eq = (e.f == 4'hF);
        return e;
    endfunction

    task automatic compare(input exp_t e);
        check("F", {4'd0, F}, {4'd0, e.f});
        check("cout", {7'd0, cout}, {7'd0, e.co});
        check("eqAB", {7'd0, eqAB}, {7'd0, e.eq});
`ifdef ALU_PG_EN
        check("P", {7'd0, P}, {7'd0, e.p});
        check("G", {7'd0, G}, {7'd0, e.g});
        if (!e.m) check("pg_invariant", {7'd0, cout}, {7'd0, G | (P & e.c)});
`endif
    endtask

    // Outputs at this negedge reflect the sample taken at the preceding posedge.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                         input logic m, input logic c, input exp_t e);
        @(negedge clk);
        if (sb.size() > 0) compare(sb.pop_front());
        A = a; B = b; sel = s; mode = m; cin = c;
        sb.push_back(e);
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                        input logic m, input logic c);
        drive(a, b, s, m, c, model(a, b, s, m, c));
    endtask

    task automatic step_exp(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                            input logic m, input logic c,
                            input logic [3:0] ef, input logic eco, input logic eeq);
        exp_t e;
        e = model(a, b, s, m, c);
        e.f = ef;
        e.co = eco;
        e.eq = eeq;
        drive(a, b, s, m, c, e);
    endtask

    task automatic flush();
        @(negedge clk);
        if (sb.size() > 0) compare(sb.pop_front());
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_F"}, {4'd0, F}, 8'd0);
        check({tag, "_cout"}, {7'd0, cout}, 8'd0);
        check({tag, "_eqAB"}, {7'd0, eqAB}, 8'd0);
    endtask

    initial begin
        #1;
        check_zero("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Compare-equal and subtract with cin
        step_exp(4'b1010, 4'b1010, 4'b0110, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1);
        step_exp(4'b1010, 4'b1010, 4'b0110, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0);
        // Add with wrap
        step_exp(4'b1111, 4'b0001, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        step_exp(4'b1111, 4'b0001, 4'b1001, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
        // Directed logic points
        step_exp(4'b1100, 4'b1010, 4'b0110, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
        step_exp(4'b1100, 4'b1010, 4'b1011, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0);
        step_exp(4'b1100, 4'b1010, 4'b0000, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0);

        for (int s = 0; s < 16; s++) step(4'b1100, 4'b1010, 4'(s), 1'b1, 1'b1);
        for (int s = 0; s < 16; s++)
            for (int c = 0; c < 2; c++) step(4'b0101, 4'b0011, 4'(s), 1'b0, 1'(c));

        // Inputs change every cycle
        for (int i = 0; i < 200; i++)
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        step_exp(4'b1111, 4'b0001, 4'b1001, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
        flush();
        check("pre_reset_F", {4'd0, F}, 8'd1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("reset_async");
        @(posedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        A = 4'b1010; B = 4'b1010; sel = 4'b0110; mode = 1'b0; cin = 1'b0;
        #3 check_zero("reset_release");
        @(posedge clk);
        #1;
        check("post_reset_F", {4'd0, F}, 8'h0F);
        check("post_reset_eqAB", {7'd0, eqAB}, 8'd1);
        check("post_reset_cout", {7'd0, cout}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
